// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - per-frame walk/jump/fall sequencer for the player sprite
// Position, facing and animation select all advance only on frame_tick.
module player_motion_ctrl #(
   parameter int X_MAX     = 503,
   parameter int Y_FLOOR   = 359,
   parameter int SPEED     = 2,
   parameter int JUMP_V    = 12,
   parameter int GRAVITY   = 1,
   parameter int VMAX      = 12,
   parameter int FRAME_DIV = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       frame_tick,
   input  logic       left,
   input  logic       right,
   input  logic       jump,
   output logic [9:0] x_pos,
   output logic [8:0] y_pos,
   output logic [1:0] anim_sel,
   output logic       facing,
   output logic [1:0] state
);

   localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WALK = 2'd1;
   localparam logic [1:0] ST_RISE = 2'd2;
   localparam logic [1:0] ST_FALL = 2'd3;

   logic [9:0]    r_x;
   logic [8:0]    r_y;
   logic [4:0]    r_vy;
   logic          r_armed;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_anim;
   logic          r_facing;
   logic [1:0]    r_state;

   logic [9:0]    w_x_nxt;
   logic [8:0]    w_y_nxt;
   logic [4:0]    w_vy_nxt;
   logic          w_armed_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [1:0]    w_anim_nxt;
   logic          w_facing_nxt;
   logic [1:0]    w_state_nxt;

   logic [10:0]   w_x_ext;
   logic [10:0]   w_x_inc;
   logic [4:0]    w_vy_rise;
   logic [5:0]    w_vy_sum;
   logic [4:0]    w_vy_fall;
   logic [10:0]   w_y_fall;

   assign w_x_ext   = {1'b0, r_x};
   assign w_x_inc   = w_x_ext + 11'(SPEED);
   assign w_vy_rise = r_vy - 5'(GRAVITY);
   assign w_vy_sum  = {1'b0, r_vy} + 6'(GRAVITY);
   assign w_vy_fall = (w_vy_sum > 6'(VMAX)) ? 5'(VMAX) : w_vy_sum[4:0];
   assign w_y_fall  = {2'b00, r_y} + {6'd0, w_vy_fall};

   always_comb begin
      w_x_nxt      = r_x;
      w_facing_nxt = r_facing;
      w_y_nxt      = r_y;
      w_vy_nxt     = r_vy;
      w_state_nxt  = r_state;
      w_armed_nxt  = r_armed;
      w_cnt_nxt    = r_cnt;
      w_anim_nxt   = r_anim;

      if (left && !right) begin
         w_facing_nxt = 1'b1;
         w_x_nxt      = (w_x_ext < 11'(SPEED)) ? 10'd0 : 10'(w_x_ext - 11'(SPEED));
      end else if (right && !left) begin
         w_facing_nxt = 1'b0;
         w_x_nxt      = (w_x_inc > 11'(X_MAX)) ? 10'(X_MAX) : w_x_inc[9:0];
      end

      if (!jump)
         w_armed_nxt = 1'b1;

      case (r_state)
         ST_IDLE, ST_WALK: begin
            if (jump && r_armed) begin
               w_state_nxt = ST_RISE;
               w_vy_nxt    = 5'(JUMP_V);
               w_armed_nxt = 1'b0;
            end else if (left ^ right) begin
               w_state_nxt = ST_WALK;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RISE: begin
            // Ceiling clamp: a speed larger than the remaining height stops the climb at row 0.
            if ({4'd0, r_vy} > r_y) begin
               w_y_nxt     = 9'd0;
               w_vy_nxt    = 5'd0;
               w_state_nxt = ST_FALL;
            end else begin
               w_y_nxt  = r_y - {4'd0, r_vy};
               w_vy_nxt = w_vy_rise;
               if (w_vy_rise == 5'd0)
                  w_state_nxt = ST_FALL;
            end
         end
         default: begin
            if (w_y_fall >= 11'(Y_FLOOR)) begin
               w_y_nxt     = 9'(Y_FLOOR);
               w_vy_nxt    = 5'd0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_y_nxt  = w_y_fall[8:0];
               w_vy_nxt = w_vy_fall;
            end
         end
      endcase

      if (r_state == ST_IDLE) begin
         w_cnt_nxt  = '0;
         w_anim_nxt = 2'd0;
      end else if (r_cnt == CW'(FRAME_DIV - 1)) begin
         w_cnt_nxt  = '0;
         w_anim_nxt = r_anim + 2'd1;
      end else begin
         w_cnt_nxt  = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_x      <= 10'd0;
         r_y      <= 9'(Y_FLOOR);
         r_vy     <= 5'd0;
         r_armed  <= 1'b1;
         r_cnt    <= '0;
         r_anim   <= 2'd0;
         r_facing <= 1'b0;
         r_state  <= ST_IDLE;
      end else if (frame_tick) begin
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_vy     <= w_vy_nxt;
         r_armed  <= w_armed_nxt;
         r_cnt    <= w_cnt_nxt;
         r_anim   <= w_anim_nxt;
         r_facing <= w_facing_nxt;
         r_state  <= w_state_nxt;
      end
   end

   assign x_pos    = r_x;
   assign y_pos    = r_y;
   assign anim_sel = r_anim;
   assign facing   = r_facing;
   assign state    = r_state;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb/tb_player_motion_ctrl.sv - directed vector bench for player_motion_ctrl
module tb_player_motion_ctrl;

   logic       clk;
   logic       rstn;
   logic       frame_tick;
   logic       left;
   logic       right;
   logic       jump;
   logic [9:0] x_pos;
   logic [8:0] y_pos;
   logic [1:0] anim_sel;
   logic       facing;
   logic [1:0] state;

   logic       c_tick;
   logic       c_jump;
   logic       c_lr;
   logic [9:0] c_x;
   logic [8:0] c_y;
   logic [1:0] c_anim;
   logic       c_facing;
   logic [1:0] c_state;

   int n_chk;
   int n_err;

   typedef struct {
      logic l;
      logic r;
      logic j;
      int   x;
      int   y;
      int   anim;
      int   face;
      int   st;
   } vec_t;

   vec_t vecs[8];

   player_motion_ctrl u_dut (
      .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
      .left(left), .right(right), .jump(jump),
      .x_pos(x_pos), .y_pos(y_pos), .anim_sel(anim_sel),
      .facing(facing), .state(state)
   );

   player_motion_ctrl #(.JUMP_V(31), .Y_FLOOR(40)) u_ceil (
      .clk(clk), .rstn(rstn), .frame_tick(c_tick),
      .left(c_lr), .right(c_lr), .jump(c_jump),
      .x_pos(c_x), .y_pos(c_y), .anim_sel(c_anim),
      .facing(c_facing), .state(c_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic l, input logic r, input logic j);
      left = l; right = r; jump = j;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic ctick(input logic j);
      c_jump = j;
      c_tick = 1'b1;
      @(negedge clk);
      c_tick = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      frame_tick = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      frame_tick = 1'b0;
   endtask

   initial begin
      int exp_y;
      int exp_vy;
      int launches;
      logic [1:0] prev_st;
      int ceil_y[9];

      n_chk = 0; n_err = 0;
      clk = 1'b0; rstn = 1'b0; frame_tick = 1'b0;
      left = 1'b0; right = 1'b0; jump = 1'b0;
      c_tick = 1'b0; c_jump = 1'b0; c_lr = 1'b0;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 2, 359, 0, 0, 1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 4, 359, 0, 0, 1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 2, 359, 0, 1, 1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 0, 359, 0, 1, 1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 0, 359, 0, 1, 1};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 0, 359, 0, 1, 0};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 0, 359, 0, 1, 0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 2, 359, 0, 0, 1};

      ceil_y = '{1, 3, 6, 10, 15, 21, 28, 36, 40};

      @(negedge clk);
      do_reset();
      chk("rst_x", int'(x_pos), 0);
      chk("rst_y", int'(y_pos), 359);
      chk("rst_anim", int'(anim_sel), 0);
      chk("rst_face", int'(facing), 0);
      chk("rst_state", int'(state), 0);
      chk("ceil_rst_y", int'(c_y), 40);

      for (int i = 0; i < 8; i++) begin
         tick(vecs[i].l, vecs[i].r, vecs[i].j);
         chk($sformatf("vec%0d_x", i), int'(x_pos), vecs[i].x);
         chk($sformatf("vec%0d_y", i), int'(y_pos), vecs[i].y);
         chk($sformatf("vec%0d_anim", i), int'(anim_sel), vecs[i].anim);
         chk($sformatf("vec%0d_face", i), int'(facing), vecs[i].face);
         chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      end

      // Walk right from reset until clamped at the right edge.
      do_reset();
      for (int n = 1; n <= 260; n++) begin
         tick(1'b0, 1'b1, 1'b0);
         chk($sformatf("walk%0d_x", n), int'(x_pos), (2 * n > 503) ? 503 : 2 * n);
         chk($sformatf("walk%0d_state", n), int'(state), 1);
         chk($sformatf("walk%0d_anim", n), int'(anim_sel), ((n - 1) / 8) % 4);
      end
      tick(1'b1, 1'b1, 1'b0);
      chk("both_x", int'(x_pos), 503);
      chk("both_state", int'(state), 0);

      // Full jump profile.
      tick(1'b0, 1'b0, 1'b1);
      chk("launch_state", int'(state), 2);
      chk("launch_y", int'(y_pos), 359);
      exp_y = 359; exp_vy = 12;
      for (int k = 1; k <= 12; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         exp_y = exp_y - exp_vy;
         exp_vy = exp_vy - 1;
         chk($sformatf("rise%0d_y", k), int'(y_pos), exp_y);
      end
      chk("apex_y", int'(y_pos), 281);
      chk("apex_state", int'(state), 3);
      for (int k = 1; k <= 12; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         chk($sformatf("fall%0d_state", k), int'(state), (k == 12) ? 0 : 3);
      end
      chk("land_y", int'(y_pos), 359);

      // Holding jump launches exactly once; release re-arms.
      launches = 0;
      prev_st = state;
      for (int k = 0; k < 60; k++) begin
         tick(1'b0, 1'b0, 1'b1);
         if (state == 2'd2 && prev_st[1] == 1'b0)
            launches++;
         prev_st = state;
      end
      chk("hold_launches", launches, 1);
      chk("hold_end_state", int'(state), 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      chk("rearm_state", int'(state), 2);
      repeat (24) tick(1'b0, 1'b0, 1'b0);
      chk("rearm_land_state", int'(state), 0);
      chk("rearm_land_y", int'(y_pos), 359);

      // Inputs toggling without frame_tick must not move anything.
      for (int k = 0; k < 6; k++) begin
         left = ~left;
         @(negedge clk);
         chk($sformatf("gate%0d_x", k), int'(x_pos), 503);
         chk($sformatf("gate%0d_state", k), int'(state), 0);
      end
      left = 1'b0;

      // Reset at the apex snaps back to the floor.
      tick(1'b0, 1'b0, 1'b1);
      repeat (12) tick(1'b0, 1'b0, 1'b0);
      chk("apex2_y", int'(y_pos), 281);
      chk("apex2_state", int'(state), 3);
      rstn = 1'b0;
      frame_tick = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      frame_tick = 1'b0;
      chk("midair_rst_y", int'(y_pos), 359);
      chk("midair_rst_state", int'(state), 0);
      chk("midair_rst_x", int'(x_pos), 0);

      // Ceiling clamp instance: JUMP_V=31, Y_FLOOR=40.
      ctick(1'b1);
      chk("ceil_launch_state", int'(c_state), 2);
      chk("ceil_launch_y", int'(c_y), 40);
      ctick(1'b0);
      chk("ceil_rise_y", int'(c_y), 9);
      chk("ceil_rise_state", int'(c_state), 2);
      ctick(1'b0);
      chk("ceil_clamp_y", int'(c_y), 0);
      chk("ceil_clamp_state", int'(c_state), 3);
      for (int k = 0; k < 9; k++) begin
         ctick(1'b0);
         chk($sformatf("ceil_fall%0d_y", k), int'(c_y), ceil_y[k]);
         chk($sformatf("ceil_fall%0d_state", k), int'(c_state), (k == 8) ? 0 : 3);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
